// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared SWHB size codes, LSU state encoding and address helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

  localparam logic [1:0] SWHB_WORD = 2'b01;
  localparam logic [1:0] SWHB_HALF = 2'b10;
  localparam logic [1:0] SWHB_BYTE = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // A size code of 00 behaves as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] swhb, input logic [1:0] addr_lo);
    case (swhb)
      SWHB_BYTE: is_misaligned = 1'b0;
      SWHB_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] lane_addr(input logic [1:0] swhb, input logic [1:0] addr_lo);
    case (swhb)
      SWHB_BYTE: lane_addr = addr_lo;
      SWHB_HALF: lane_addr = {addr_lo[1], 1'b0};
      default:   lane_addr = 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/flopenr.sv
// ============================================================================
// Module      : flopenr
// Description : Enabled register with asynchronous active-high reset to zero.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/half of a read word and sign- or
//               zero-extends it to XLEN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      swhb,
  input  logic            lu,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (swhb)
      SWHB_BYTE: ext = {{(XLEN-8){~lu & w_byte[7]}}, w_byte};
      SWHB_HALF: ext = {{(XLEN-16){~lu & w_half[15]}}, w_half};
      default:   ext = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store controller: handshakes with data memory,
//               stalls the pipeline, returns extended load data.
//               MISALIGN_TRAP_EN: reject misaligned requests with a pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [1:0]           req_swhb,
  input  logic                 req_lu,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [3:0]           amp,
  output logic                 stall,
  output logic                 ld_valid,
  output logic [XLEN-1:0]      ld_data,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 misaligned
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic                 w_mis;
  logic [1:0]           w_lane;
  logic                 w_accept;
  logic                 w_capture;
  logic [XLEN-1:0]      w_wdata_rep;
  logic [XLEN-1:0]      w_ext;

  logic                 r_we;
  logic [1:0]           r_swhb;
  logic                 r_lu;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [3:0]           r_be;

`ifdef MISALIGN_TRAP_EN
  assign w_mis  = is_misaligned(req_swhb, req_addr[1:0]);
  assign w_lane = req_addr[1:0];
`else
  // Misaligned low bits are dropped so the access lands on the enclosing lane.
  assign w_mis  = 1'b0;
  assign w_lane = lane_addr(req_swhb, req_addr[1:0]);
`endif

  always_comb begin
    w_wdata_rep = req_wdata;
    case (req_swhb)
      SWHB_BYTE: w_wdata_rep = {(XLEN/8){req_wdata[7:0]}};
      SWHB_HALF: w_wdata_rep = {(XLEN/16){req_wdata[15:0]}};
      default:   w_wdata_rep = req_wdata;
    endcase
  end

  flopenr #(.WIDTH(1)) u_we_reg (
    .clk(clk), .reset(reset), .en(w_accept), .d(req_we), .q(r_we)
  );
  flopenr #(.WIDTH(2)) u_swhb_reg (
    .clk(clk), .reset(reset), .en(w_accept), .d(req_swhb), .q(r_swhb)
  );
  flopenr #(.WIDTH(1)) u_lu_reg (
    .clk(clk), .reset(reset), .en(w_accept), .d(req_lu), .q(r_lu)
  );
  flopenr #(.WIDTH(ADDR_SIZE)) u_addr_reg (
    .clk(clk), .reset(reset), .en(w_accept),
    .d({req_addr[ADDR_SIZE-1:2], w_lane}), .q(r_addr)
  );
  flopenr #(.WIDTH(XLEN)) u_wdata_reg (
    .clk(clk), .reset(reset), .en(w_accept), .d(w_wdata_rep), .q(r_wdata)
  );
  flopenr #(.WIDTH(4)) u_be_reg (
    .clk(clk), .reset(reset), .en(w_accept), .d(amp), .q(r_be)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= LSU_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    ld_valid   = 1'b0;
    misaligned = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        // Requests seen while reset is held must not stall or latch.
        if (req_valid && !reset) begin
          if (w_mis) begin
            misaligned = 1'b1;
          end else begin
            w_accept = 1'b1;
            stall    = 1'b1;
            w_next   = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        if (dmem_ack) begin
          w_capture = ~r_we;
          w_next    = LSU_DONE;
        end
      end
      LSU_DONE: begin
        ld_valid = ~r_we;
        w_next   = LSU_IDLE;
      end
      default: w_next = LSU_IDLE;
    endcase
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = {r_addr[ADDR_SIZE-1:2], 2'b00};
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata(dmem_rdata),
    .addr (r_addr[1:0]),
    .swhb (r_swhb),
    .lu   (r_lu),
    .ext  (w_ext)
  );

  flopenr #(.WIDTH(XLEN)) u_ld_data_reg (
    .clk(clk), .reset(reset), .en(w_capture), .d(w_ext), .q(ld_data)
  );

endmodule

`default_nettype wire
